cordic_iter_sched: RTL

- Iteration sequencer for the iterative hyperbolic-CORDIC sigmoid/tanh evaluator.
- Accepts one job (iteration count M, function mode) per valid/ready handshake.
- Issues a one-cycle load strobe, then one step-enable per iteration with the current shift index j. Inserts the mandatory hyperbolic repeat iterations, detects termination (j == M) and presents a done/valid handshake downstream.
- Sits between the activation-function request logic and the CORDIC datapath; owns the loop counter and termination compare.

---
 rtl/cordic_iter_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cordic_iter_sched.sv
// Iteration sequencer for the iterative hyperbolic-CORDIC sigmoid/tanh evaluator.
// Issues a load strobe, one step-enable per iteration (with repeats at REP_A/REP_B),
// then holds a done/valid handshake until the consumer takes the result.
module cordic_iter_sched #(
    parameter int unsigned MW    = 5,
    parameter int unsigned REP_A = 4,
    parameter int unsigned REP_B = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] M,
    input  logic          mode,
    input  logic          abort,
    output logic          dp_load,
    output logic          dp_en,
    output logic [MW-1:0] j_idx,
    output logic          mode_q,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned    J_MAX     = (1 << MW) - 1;
    localparam bit             REP_A_OK  = (REP_A <= J_MAX);
    localparam bit             REP_B_OK  = (REP_B <= J_MAX);
    localparam logic [MW-1:0]  REP_A_IDX = MW'(REP_A);
    localparam logic [MW-1:0]  REP_B_IDX = MW'(REP_B);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   m_q, m_d;
    logic [MW-1:0]   j_q, j_d;
    logic            rep_done_q, rep_done_d;
    logic            mode_cap_q, mode_cap_d;
    logic            is_rep;

    // Current index is one of the hyperbolic convergence repeats not yet re-issued.
    always_comb begin
        is_rep = 1'b0;
        if (!rep_done_q) begin
            is_rep = (REP_A_OK && (j_q == REP_A_IDX)) ||
                     (REP_B_OK && (j_q == REP_B_IDX));
        end
    end

    // State and job-context registers; synchronous reset has top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            j_q        <= '0;
            rep_done_q <= 1'b0;
            mode_cap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            j_q        <= j_d;
            rep_done_q <= rep_done_d;
            mode_cap_q <= mode_cap_d;
        end
    end

    // Next-state logic: accept, load, iterate with repeats, terminate on j == m_q, hand off.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        j_d        = j_q;
        rep_done_d = rep_done_q;
        mode_cap_d = mode_cap_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !abort) begin
                    state_d    = S_LOAD;
                    m_d        = M;
                    mode_cap_d = mode;
                    j_d        = MW'(1);
                    rep_done_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (m_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (is_rep) begin
                    rep_done_d = 1'b1;
                end else if (j_q == m_q) begin
                    state_d = S_DONE;
                end else begin
                    j_d        = j_q + MW'(1);
                    rep_done_d = 1'b0;
                end
            end
            S_DONE: begin
                if (abort || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving a job clears the loop context so IDLE presents a clean zero state.
        if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
            j_d        = '0;
            rep_done_d = 1'b0;
            mode_cap_d = 1'b0;
        end
    end

    // Moore output decode from the registered state; in_ready is also masked by reset.
    always_comb begin
        in_ready  = 1'b0;
        dp_load   = 1'b0;
        dp_en     = 1'b0;
        j_idx     = '0;
        busy      = 1'b0;
        out_valid = 1'b0;
        mode_q    = mode_cap_q;

        case (state_q)
            S_IDLE: in_ready = !rst;
            S_LOAD: begin
                dp_load = 1'b1;
                busy    = 1'b1;
            end
            S_ITER: begin
                dp_en = 1'b1;
                j_idx = j_q;
                busy  = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
